// File: rtl/stepper_step_sequencer_pkg.sv
// Shared types and constants for the stepper step sequencer:
// state encoding, coil table and phase-advance helper.
package stepper_pkg;

    localparam int unsigned PHASE_W = 3;
    localparam int unsigned COIL_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        WAIT,
        DONE
    } state_t;

    // Index 0 is the rightmost entry; odd indices are the two-coil patterns.
    localparam logic [7:0][COIL_W-1:0] HALF_STEP_TABLE = {
        4'b1001, 4'b0001, 4'b0011, 4'b0010,
        4'b0110, 4'b0100, 4'b1100, 4'b1000
    };

    // Full step snaps to the odd (two-coil) entry before moving two places.
    function automatic logic [PHASE_W-1:0] next_phase(
        input logic [PHASE_W-1:0] idx,
        input logic               dir,
        input logic               half
    );
        logic [PHASE_W-1:0] base;
        logic [PHASE_W-1:0] inc;
        base = half ? idx : (idx | PHASE_W'(1));
        inc  = half ? PHASE_W'(1) : PHASE_W'(2);
        return dir ? (base + inc) : (base - inc);
    endfunction

endpackage

// File: rtl/stepper_step_sequencer_if.sv
// Command/status bundle between the register interface and the step sequencer.
interface stepper_step_sequencer_if
    import stepper_pkg::*;
#(
    parameter int unsigned STEPS_W = 16
);

    logic               cmd_valid;
    logic               cmd_ready;
    logic [STEPS_W-1:0] cmd_steps;
    logic               cmd_dir;
    logic [7:0]         cmd_delay;
    logic               cmd_half;
    logic               abort;
    logic               busy;
    logic [COIL_W-1:0]  coils;
    logic               step_pulse;
    logic               done;
    logic               aborted;
    logic [STEPS_W-1:0] steps_left;

    modport master (
        output cmd_valid, cmd_steps, cmd_dir, cmd_delay, cmd_half, abort,
        input  cmd_ready, busy, coils, step_pulse, done, aborted, steps_left
    );

    modport slave (
        input  cmd_valid, cmd_steps, cmd_dir, cmd_delay, cmd_half, abort,
        output cmd_ready, busy, coils, step_pulse, done, aborted, steps_left
    );

endinterface

// File: rtl/stepper_step_sequencer_timer.sv
// Step interval timer: start reloads, enable counts BASE_PERIOD ticks per delay
// unit, expired pulses in the delay*BASE_PERIOD-th enabled cycle.
module step_interval_timer #(
    parameter logic [19:0] BASE_PERIOD = 20'd500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       enable,
    input  logic [7:0] delay,
    output logic       expired
);

    localparam logic [19:0] TICK_LAST = BASE_PERIOD - 20'd1;

    logic [19:0] tick_q;
    logic [7:0]  units_q;

    assign expired = enable && (units_q == 8'd1) && (tick_q == TICK_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_q  <= '0;
            units_q <= '0;
        end else if (start) begin
            tick_q  <= '0;
            units_q <= (delay == 8'd0) ? 8'd1 : delay;
        end else if (!enable) begin
            // Idle or aborted: drop any partial count.
            tick_q  <= '0;
            units_q <= '0;
        end else if (units_q != 8'd0) begin
            if (tick_q == TICK_LAST) begin
                tick_q  <= '0;
                units_q <= units_q - 8'd1;
            end else begin
                tick_q <= tick_q + 20'd1;
            end
        end
    end

endmodule

// File: rtl/stepper_step_sequencer.sv
// Stepper move sequencer: accepts a move command, advances the coil phase once
// per step interval and reports completion or abort.
module stepper_step_sequencer
    import stepper_pkg::*;
#(
    parameter logic [19:0] BASE_PERIOD = 20'd500000,
    parameter int unsigned STEPS_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    stepper_step_sequencer_if.slave  bus
);

    state_t             state_q;
    logic [PHASE_W-1:0] idx_q;
    logic [PHASE_W-1:0] idx_d;
    logic [COIL_W-1:0]  coils_q;
    logic [STEPS_W-1:0] steps_left_q;
    logic [7:0]         delay_q;
    logic               dir_q;
    logic               half_q;
    logic               step_pulse_q;
    logic               done_q;
    logic               aborted_q;
    logic               timer_start;
    logic               timer_en;
    logic               timer_expired;

    // The first step of a move uses the incoming command fields, later ones the latched copy.
    assign idx_d = (state_q == IDLE) ? next_phase(idx_q, bus.cmd_dir, bus.cmd_half)
                                     : next_phase(idx_q, dir_q, half_q);

    assign timer_start = (state_q == STEP);
    assign timer_en    = (state_q == WAIT) && !bus.abort;

    step_interval_timer #(
        .BASE_PERIOD(BASE_PERIOD)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (timer_start),
        .enable (timer_en),
        .delay  (delay_q),
        .expired(timer_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            coils_q      <= '0;
            steps_left_q <= '0;
            delay_q      <= 8'd1;
            dir_q        <= 1'b0;
            half_q       <= 1'b0;
            step_pulse_q <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            step_pulse_q <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        dir_q     <= bus.cmd_dir;
                        half_q    <= bus.cmd_half;
                        delay_q   <= (bus.cmd_delay == 8'd0) ? 8'd1 : bus.cmd_delay;
                        aborted_q <= 1'b0;
                        if (bus.cmd_steps == '0) begin
                            steps_left_q <= '0;
                            done_q       <= 1'b1;
                            state_q      <= DONE;
                        end else begin
                            steps_left_q <= bus.cmd_steps - STEPS_W'(1);
                            idx_q        <= idx_d;
                            coils_q      <= HALF_STEP_TABLE[idx_d];
                            step_pulse_q <= 1'b1;
                            state_q      <= STEP;
                        end
                    end
                end
                STEP: begin
                    if (bus.abort) begin
                        done_q    <= 1'b1;
                        aborted_q <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.abort) begin
                        done_q    <= 1'b1;
                        aborted_q <= 1'b1;
                        state_q   <= DONE;
                    end else if (timer_expired) begin
                        if (steps_left_q == '0) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            steps_left_q <= steps_left_q - STEPS_W'(1);
                            idx_q        <= idx_d;
                            coils_q      <= HALF_STEP_TABLE[idx_d];
                            step_pulse_q <= 1'b1;
                            state_q      <= STEP;
                        end
                    end
                end
                DONE: begin
                    aborted_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready  = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.coils      = coils_q;
    assign bus.step_pulse = step_pulse_q;
    assign bus.done       = done_q;
    assign bus.aborted    = aborted_q;
    assign bus.steps_left = steps_left_q;

endmodule

// File: tb/tb_stepper_step_sequencer.sv
// Directed bench for stepper_step_sequencer with BASE_PERIOD = 4.
module tb_stepper_step_sequencer;
    import stepper_pkg::*;

    localparam int unsigned STEPS_W = 16;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    stepper_step_sequencer_if #(.STEPS_W(STEPS_W)) bus ();

    stepper_step_sequencer #(
        .BASE_PERIOD(20'd4),
        .STEPS_W    (STEPS_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic             pre_reset;
        logic [15:0]      steps;
        logic             dir;
        logic [7:0]       delay;
        logic             half;
        int               abort_cyc;
        int               npulse;
        int               spacing;
        logic [3:0][3:0]  coils;   // element 0 = first pulse
        logic [3:0][15:0] sl;
        int               done_cyc;
        logic [15:0]      final_sl;
        logic             aborted;
        logic [3:0]       final_coils;
    } vec_t;

    vec_t vecs [5];
    vec_t va1, vb, vr;
    int   nvec = 0;
    int   nbad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Entered at the negedge of cycle 0 (the first cycle after acceptance).
    task automatic monitor(input vec_t v, input string tag);
        int   cyc;
        int   np;
        logic seen_done;
        cyc = 0;
        np = 0;
        seen_done = 1'b0;
        while (!seen_done && cyc <= v.done_cyc + 20) begin
            bus.abort = (cyc == v.abort_cyc);
            if (bus.step_pulse) begin
                if (np < 4) begin
                    check({tag, ".coils"}, 32'(bus.coils), 32'(v.coils[np]));
                    check({tag, ".steps_left"}, 32'(bus.steps_left), 32'(v.sl[np]));
                    check({tag, ".pulse_cycle"}, cyc, np * v.spacing);
                end
                np++;
            end
            if (bus.done) begin
                seen_done = 1'b1;
                check({tag, ".done_cycle"}, cyc, v.done_cyc);
                check({tag, ".aborted"}, 32'(bus.aborted), 32'(v.aborted));
                check({tag, ".final_steps_left"}, 32'(bus.steps_left), 32'(v.final_sl));
                check({tag, ".final_coils"}, 32'(bus.coils), 32'(v.final_coils));
                check({tag, ".busy_in_done"}, 32'(bus.busy), 1);
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        bus.abort = 1'b0;
        if (!seen_done) check({tag, ".done_timeout"}, 0, 1);
        check({tag, ".npulse"}, np, v.npulse);
        @(negedge clk);
        check({tag, ".busy_after"}, 32'(bus.busy), 0);
        check({tag, ".ready_after"}, 32'(bus.cmd_ready), 1);
        check({tag, ".done_after"}, 32'(bus.done), 0);
    endtask

    task automatic run_move(input vec_t v, input string tag);
        if (v.pre_reset) do_reset();
        @(negedge clk);
        check({tag, ".ready"}, 32'(bus.cmd_ready), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_steps = v.steps;
        bus.cmd_dir   = v.dir;
        bus.cmd_delay = v.delay;
        bus.cmd_half  = v.half;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        monitor(v, tag);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_steps = '0;
        bus.cmd_dir   = 1'b0;
        bus.cmd_delay = '0;
        bus.cmd_half  = 1'b0;
        bus.abort     = 1'b0;
        reset         = 1'b1;

        // pre_reset, steps, dir, delay, half, abort_cyc, npulse, spacing, coils, sl, done_cyc, final_sl, aborted, final_coils
        vecs[0] = '{1'b0, 16'd3, 1'b1, 8'd2, 1'b1, -1, 3, 9,
                    {4'b0000, 4'b0110, 4'b0100, 4'b1100}, {16'd0, 16'd0, 16'd1, 16'd2},
                    27, 16'd0, 1'b0, 4'b0110};
        vecs[1] = '{1'b0, 16'd2, 1'b0, 8'd1, 1'b1, -1, 2, 5,
                    {4'b0000, 4'b0000, 4'b1100, 4'b0100}, {16'd0, 16'd0, 16'd0, 16'd1},
                    10, 16'd0, 1'b0, 4'b1100};
        vecs[2] = '{1'b0, 16'd2, 1'b0, 8'd0, 1'b0, -1, 2, 5,
                    {4'b0000, 4'b0000, 4'b0011, 4'b1001}, {16'd0, 16'd0, 16'd0, 16'd1},
                    10, 16'd0, 1'b0, 4'b0011};
        vecs[3] = '{1'b0, 16'd0, 1'b1, 8'd3, 1'b1, -1, 0, 5,
                    {4'b0000, 4'b0000, 4'b0000, 4'b0000}, {16'd0, 16'd0, 16'd0, 16'd0},
                    0, 16'd0, 1'b0, 4'b0011};
        vecs[4] = '{1'b1, 16'd10, 1'b1, 8'd1, 1'b1, 9, 2, 5,
                    {4'b0000, 4'b0000, 4'b0100, 4'b1100}, {16'd0, 16'd0, 16'd8, 16'd9},
                    10, 16'd8, 1'b1, 4'b0100};
        va1 = '{1'b0, 16'd1, 1'b1, 8'd1, 1'b1, -1, 1, 5,
                {4'b0000, 4'b0000, 4'b0000, 4'b0110}, {16'd0, 16'd0, 16'd0, 16'd0},
                5, 16'd0, 1'b0, 4'b0110};
        vb  = '{1'b0, 16'd2, 1'b0, 8'd3, 1'b0, -1, 2, 13,
                {4'b0000, 4'b0000, 4'b1001, 4'b1100}, {16'd0, 16'd0, 16'd0, 16'd1},
                26, 16'd0, 1'b0, 4'b1001};
        vr  = '{1'b0, 16'd1, 1'b1, 8'd1, 1'b1, -1, 1, 5,
                {4'b0000, 4'b0000, 4'b0000, 4'b1100}, {16'd0, 16'd0, 16'd0, 16'd0},
                5, 16'd0, 1'b0, 4'b1100};

        repeat (2) @(negedge clk);
        check("rst.coils", 32'(bus.coils), 0);
        check("rst.steps_left", 32'(bus.steps_left), 0);
        check("rst.busy", 32'(bus.busy), 0);
        check("rst.ready", 32'(bus.cmd_ready), 1);
        check("rst.step_pulse", 32'(bus.step_pulse), 0);
        check("rst.done", 32'(bus.done), 0);
        check("rst.aborted", 32'(bus.aborted), 0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) run_move(vecs[i], $sformatf("v%0d", i));

        // cmd_valid held through a move with different fields; phase index is 2 here.
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_steps = 16'd1;
        bus.cmd_dir   = 1'b1;
        bus.cmd_delay = 8'd1;
        bus.cmd_half  = 1'b1;
        @(negedge clk);
        bus.cmd_steps = 16'd2;
        bus.cmd_dir   = 1'b0;
        bus.cmd_delay = 8'd3;
        bus.cmd_half  = 1'b0;
        check("hold.ready_busy", 32'(bus.cmd_ready), 0);
        monitor(va1, "hold1");
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        monitor(vb, "hold2");

        // Asynchronous reset in the middle of WAIT; phase index is 7 here.
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_steps = 16'd4;
        bus.cmd_dir   = 1'b1;
        bus.cmd_delay = 8'd2;
        bus.cmd_half  = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst.pre_coils", 32'(bus.coils), 32'h8);
        check("midrst.pre_steps_left", 32'(bus.steps_left), 3);
        #2 reset = 1'b1;
        #1;
        check("midrst.coils", 32'(bus.coils), 0);
        check("midrst.busy", 32'(bus.busy), 0);
        check("midrst.steps_left", 32'(bus.steps_left), 0);
        check("midrst.ready", 32'(bus.cmd_ready), 1);
        @(negedge clk);
        check("midrst.no_done", 32'(bus.done), 0);
        reset = 1'b0;
        run_move(vr, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/stepper_step_sequencer.md
Name: stepper_step_sequencer

Overview:
Accepts a move command (step count, direction, per-step delay, full/half-step mode) and drives the four stepper coil outputs, one phase advance per step. Step spacing comes from an internal interval timer with the same start/enable/done countdown semantics as the team's delay counter. Sits between the command/register interface and the coil driver pins.

Parameters:
BASE_PERIOD, 500000, clock cycles per delay unit (20-bit); benches override it to 4
STEPS_W, 16, width of the step count and remaining-step counter

Ports:
clk  in  1  system clock; all state updates on posedge
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  move command present
cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready
cmd_steps  in  STEPS_W  number of steps to take
cmd_dir  in  1  1 = forward (phase index increments), 0 = reverse
cmd_delay  in  8  step interval in BASE_PERIOD units; 0 is treated as 1
cmd_half  in  1  1 = half-step mode, 0 = full-step (two-coil) mode
abort  in  1  terminate the active move
busy  out  1  high in any state other than IDLE
coils  out  4  coil drive pattern {A,B,C,D}
step_pulse  out  1  one-cycle pulse on each coil update
done  out  1  one-cycle pulse at move end, normal or aborted
aborted  out  1  valid with done: 1 = move ended by abort
steps_left  out  STEPS_W  steps still to take

Behaviour:
- Reset (async): state=IDLE, coils=0000, phase index=0, steps_left=0, step_pulse=0, done=0, aborted=0, timer cleared. cmd_ready is a decode of the IDLE state, so it reads 1 while in reset.
- Half-step table, index 0..7: 1000,1100,0100,0110,0010,0011,0001,1001.
- Phase index next value:
  - Half mode: idx±1, mod 8.
  - Full mode: (idx|1)±2, mod 8. Full mode always lands on two-coil entries.
- IDLE:
  - On accept, latch dir, half, and max(delay,1); load steps_left=cmd_steps.
  - If cmd_steps==0, go to DONE. Otherwise go to STEP.
- STEP (1 cycle):
  - Register the next phase index; coils=table[next idx].
  - step_pulse=1; steps_left decrements by 1.
  - Timer starts with the latched delay.
  - Next state: WAIT.
- WAIT:
  - The timer is enabled. Its tick counter runs 0..BASE_PERIOD-1; the delay count decrements on each wrap.
  - Expiry is asserted in the D*BASE_PERIOD-th WAIT cycle, where D = max(delay,1).
  - On expiry: if steps_left==0, go to DONE; otherwise go to STEP.
  - Result: step_pulse spacing is exactly D*BASE_PERIOD+1 cycles.
- DONE (1 cycle): done=1 and aborted=the latched abort flag. Next state: IDLE.
- Abort:
  - abort in STEP or WAIT: next state is DONE with aborted=1; steps_left holds its value; the timer clears.
  - abort has priority over timer expiry in the same cycle.
  - abort is ignored in IDLE and DONE.
- Coils hold their last pattern in IDLE and after abort; they are never cleared except by reset.
- The phase index persists across moves, so a reversal retraces the same table positions.
- cmd_valid outside IDLE is ignored; no queueing.
- Reset mid-move: immediate return to reset values; no done pulse.
- Arithmetic:
  - steps_left is unsigned, no wrap; it is only decremented in STEP, which only occurs with steps_left>0.
  - The timer counter is 20-bit. BASE_PERIOD must be ≥1.

Decomposition:
- Package stepper_pkg:
  - state enum {IDLE, STEP, WAIT, DONE}
  - 8-entry half-step coil table constant
  - phase index width (3)
  - coil width (4)
- Sub-module step_interval_timer, containing the timer logic:
  - Ports: clk, reset, start, enable, delay[7:0], expired.
  - Parameter: BASE_PERIOD.
  - Behaviour: start reloads the timer; expired is a single-cycle pulse in the D*BASE_PERIOD-th enabled cycle.
- The FSM, phase logic and handshake stay in the top level.

Test Plan:
- BASE_PERIOD=4, reset, then cmd steps=3, dir=1, half=1, delay=2 → coils 1100,0100,0110; step_pulses 9 cycles apart; steps_left 2,1,0; done=1, aborted=0 one cycle after the third expiry.
- Full mode, dir=0, steps=2, delay=0, from phase idx 1 → delay is treated as 1 (pulses 5 cycles apart); idx 7 then 5; coils 1001 then 0011.
- steps=0 → no step_pulse; busy for 1 cycle (DONE), done=1, aborted=0; coils unchanged.
- steps=10, abort asserted in the same cycle as the second WAIT expiry → no third step; done=1, aborted=1, steps_left=8; coils hold 0100 (half fwd from idx 0).
- cmd_valid held high during a move with different fields → ignored; the next command is accepted only in the IDLE cycle after done.
- reset asserted mid-WAIT (async, between edges) → coils=0000, busy=0, steps_left=0 immediately; no done pulse; the next command runs normally.
